// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and default widths for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_HOLD = 2'd3
    } arb_state_e;

    // Defaults match the SdramCtrl client port.
    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// rtl/sdram_rr_pick.sv - combinational requester pick, rotating or fixed priority
module sdram_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    input  logic                 rr_mode_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    int         start;
    int         j;
    logic [IDX_W-1:0] jj;

    // Fixed mode is a rotating search that always starts at port 0.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        jj      = '0;
        start   = rr_mode_i ? int'(ptr_i) + 1 : 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j  = (start + i) % NUM_PORTS;
            jj = IDX_W'(j);
            if (!valid_o && req_i[jj]) begin
                valid_o     = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the single SdramCtrl client port between NUM_PORTS requesters
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_WIDTH  = SDRAM_ADDR_W,
    parameter int DATA_WIDTH  = SDRAM_DATA_W,
    parameter int ROUND_ROBIN = 1,
    parameter int WR_HOLD     = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                             clk,
    input  logic                             reset_l,
    input  logic [NUM_PORTS-1:0]             p_req,
    input  logic [NUM_PORTS-1:0]             p_rh_wl,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
    output logic [NUM_PORTS-1:0]             p_ack,
    output logic [DATA_WIDTH-1:0]            p_rdata,
    output logic [NUM_PORTS-1:0]             p_rdata_en,
    output logic [NUM_PORTS-1:0]             p_err,
    output logic                             busy,
    output logic                             sdram_req,
    input  logic                             sdram_ack,
    output logic [ADDR_WIDTH-1:0]            sdram_addr,
    output logic                             sdram_rh_wl,
    output logic [DATA_WIDTH-1:0]            sdram_data_w,
    input  logic [DATA_WIDTH-1:0]            sdram_data_r,
    input  logic                             sdram_data_r_en
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(max_int(WR_HOLD, RD_TIMEOUT) + 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   rh_wl_q, rh_wl_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   req_q, req_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [NUM_PORTS-1:0]   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]   grant;
    logic [IDX_W-1:0]       win;
    logic                   win_valid;
    logic [NUM_PORTS-1:0]   owner_oh;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_split
        assign addr_arr[g]  = p_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = p_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    sdram_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i     (p_req),
        .ptr_i     (ptr_q),
        .rr_mode_i (ROUND_ROBIN != 0),
        .grant_o   (grant),
        .idx_o     (win),
        .valid_o   (win_valid)
    );

    assign owner_oh = NUM_PORTS'(1) << owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rh_wl_d = rh_wl_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_ISSUE;
                    owner_d = win;
                    ptr_d   = win;
                    addr_d  = addr_arr[win];
                    rh_wl_d = p_rh_wl[win];
                    wdata_d = wdata_arr[win];
                    ack_d   = grant;
                    req_d   = 1'b1;
                end
            end
            // No timeout here: SdramCtrl may be busy refreshing.
            ST_ISSUE: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    cnt_d = '0;
                    if (rh_wl_q) begin
                        state_d = ST_RD_WAIT;
                    end else begin
                        state_d = ST_WR_HOLD;
                        cnt_d   = CNT_W'(WR_HOLD - 1);
                    end
                end
            end
            ST_RD_WAIT: begin
                if (sdram_data_r_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = owner_oh;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
            addr_q  <= '0;
            rh_wl_q <= 1'b0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            rh_wl_q <= rh_wl_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Read-data valid is steered combinationally; stray strobes outside RD_WAIT are dropped.
    assign p_rdata_en   = (state_q == ST_RD_WAIT && sdram_data_r_en) ? owner_oh : '0;
    assign p_rdata      = sdram_data_r;
    assign p_ack        = ack_q;
    assign p_err        = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign sdram_rh_wl  = rh_wl_q;
    assign sdram_data_w = wdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized bench with a transaction-level reference model
module tb_sdram_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int WRH = 2;
    localparam int RDT = 15;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    p_req = '0, p_rh_wl = '0;
    logic [N*AW-1:0] p_addr = '0;
    logic [N*DW-1:0] p_wdata = '0;
    logic            sdram_ack = 1'b0, sdram_data_r_en = 1'b0;
    logic [DW-1:0]   sdram_data_r = '0;
    logic [N-1:0]    p_ack, p_rdata_en, p_err;
    logic [DW-1:0]   p_rdata;
    logic            busy, sdram_req, sdram_rh_wl;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_data_w;

    logic            f_ack = 1'b0, f_dre = 1'b0;
    logic [DW-1:0]   f_data_r = '0;
    logic [N-1:0]    f_p_ack, f_p_rdata_en, f_p_err;
    logic [DW-1:0]   f_p_rdata;
    logic            f_busy, f_sdram_req, f_sdram_rh_wl;
    logic [AW-1:0]   f_sdram_addr;
    logic [DW-1:0]   f_sdram_data_w;

    sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1),
                         .WR_HOLD(WRH), .RD_TIMEOUT(RDT)) u_dut (
        .clk(clk), .reset_l(reset_l), .p_req(p_req), .p_rh_wl(p_rh_wl), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_ack(p_ack), .p_rdata(p_rdata), .p_rdata_en(p_rdata_en),
        .p_err(p_err), .busy(busy), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_addr(sdram_addr), .sdram_rh_wl(sdram_rh_wl), .sdram_data_w(sdram_data_w),
        .sdram_data_r(sdram_data_r), .sdram_data_r_en(sdram_data_r_en));

    sdram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0),
                         .WR_HOLD(WRH), .RD_TIMEOUT(RDT)) u_fix (
        .clk(clk), .reset_l(reset_l), .p_req(p_req), .p_rh_wl(p_rh_wl), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_ack(f_p_ack), .p_rdata(f_p_rdata), .p_rdata_en(f_p_rdata_en),
        .p_err(f_p_err), .busy(f_busy), .sdram_req(f_sdram_req), .sdram_ack(f_ack),
        .sdram_addr(f_sdram_addr), .sdram_rh_wl(f_sdram_rh_wl), .sdram_data_w(f_sdram_data_w),
        .sdram_data_r(f_data_r), .sdram_data_r_en(f_dre));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one access in flight, described by age since sdram_ack.
    bit            m_active, m_acked, m_rh;
    int            m_owner, m_ptr, m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_ack, m_err;
    logic [DW-1:0] m_mem [logic [AW-1:0]];
    logic [DW-1:0] s_mem [logic [AW-1:0]];

    int ack_pct = 100, dre_pct = 0, req_pct = 0;
    bit ack_block = 0, dre_block = 0, auto_req = 0;
    int ack_cnt [N];
    logic [N-1:0]  ren_seen;
    logic [DW-1:0] rdata_seen;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_acked = 0; m_rh = 0; m_owner = 0; m_ptr = N - 1; m_age = 0;
        m_addr = '0; m_wdata = '0; m_ack = '0; m_err = '0;
    endtask

    // Winner is the requester closest after the pointer, going upward with wrap.
    function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
        int best = -1, bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - ptr - 1 + N) % N;
            if (req[i] && d < bestd) begin best = i; bestd = d; end
        end
        return best;
    endfunction

    task automatic model_step();
        int w;
        m_ack = '0; m_err = '0;
        if (!m_active) begin
            w = rr_winner(p_req, m_ptr);
            if (w >= 0) begin
                m_active = 1; m_acked = 0; m_owner = w; m_ptr = w;
                m_addr = p_addr[w*AW +: AW]; m_rh = p_rh_wl[w]; m_wdata = p_wdata[w*DW +: DW];
                m_ack[w] = 1'b1;
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                m_acked = 1; m_age = 0;
                if (!m_rh) m_mem[m_addr] = m_wdata;
            end
        end else if (m_rh) begin
            if (sdram_data_r_en) m_active = 0;
            else begin
                m_age++;
                if (m_age == RDT) begin m_active = 0; m_err[m_owner] = 1'b1; end
            end
        end else begin
            m_age++;
            if (m_age == WRH) m_active = 0;
        end
    endtask

    task automatic check();
        logic [N-1:0]  exp_ren;
        logic [DW-1:0] exp_d;
        exp_ren = (m_active && m_acked && m_rh && sdram_data_r_en) ? N'(1) << m_owner : '0;
        cmp("busy", busy, m_active);
        cmp("sdram_req", sdram_req, m_active && !m_acked);
        cmp("p_ack", p_ack, m_ack);
        cmp("p_err", p_err, m_err);
        cmp("p_rdata_en", p_rdata_en, exp_ren);
        cmp("hold_regs", {sdram_addr, sdram_rh_wl, sdram_data_w}, {m_addr, m_rh, m_wdata});
        cmp("p_rdata_copy", p_rdata, sdram_data_r);
        if (exp_ren != '0) begin
            exp_d = m_mem.exists(m_addr) ? m_mem[m_addr] : '0;
            cmp("read_data", p_rdata, exp_d);
        end
        if (p_rdata_en != '0) begin ren_seen |= p_rdata_en; rdata_seen = p_rdata; end
    endtask

    task automatic tick();
        #1;
        check();
        @(posedge clk);
        if (reset_l) model_step();
        #1;
        for (int i = 0; i < N; i++) if (p_ack[i]) ack_cnt[i]++;
    endtask

    task automatic drive_stub();
        sdram_ack = !ack_block && ($urandom_range(99) < ack_pct);
        if (sdram_ack && sdram_req && !sdram_rh_wl) s_mem[sdram_addr] = sdram_data_w;
        sdram_data_r_en = !dre_block && ($urandom_range(99) < dre_pct);
        if (sdram_data_r_en) sdram_data_r = s_mem.exists(sdram_addr) ? s_mem[sdram_addr] : '0;
        else sdram_data_r = DW'($urandom);
        f_ack = f_sdram_req;
        f_dre = 1'b1;
        f_data_r = '0;
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (!p_req[i] || p_ack[i]) begin
                if ($urandom_range(99) < req_pct) begin
                    p_req[i] = 1'b1;
                    p_rh_wl[i] = 1'($urandom_range(1));
                    p_addr[i*AW +: AW] = AW'(24'h000100 + $urandom_range(7));
                    p_wdata[i*DW +: DW] = DW'($urandom);
                end else begin
                    p_req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        drive_stub();
        if (auto_req) drive_req();
        tick();
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy && c < bound) begin step(); c++; end
        cmp("wait_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        p_req = '0; sdram_ack = 1'b0; sdram_data_r_en = 1'b0; sdram_data_r = '0;
        model_reset();
        #1;
        cmp("reset_outputs", {p_ack, p_rdata_en, p_err, busy, sdram_req, sdram_addr,
                              sdram_rh_wl, sdram_data_w, p_rdata}, '0);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
    endtask

    task automatic issue(input int port, input bit rh, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int n_ack);
        int c = 0;
        n_ack = 0;
        p_req[port] = 1'b1; p_rh_wl[port] = rh;
        p_addr[port*AW +: AW] = a; p_wdata[port*DW +: DW] = d;
        while (n_ack == 0 && c < 200) begin
            step(); c++;
            if (p_ack[port]) n_ack++;
        end
        p_req[port] = 1'b0;
        cmp("issue_acked", n_ack, 1);
    endtask

    initial begin
        int n, k, idx, fgr, rd_cnt, c;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        do_reset();

        // Write 0xBEEF from port 2, then read it back.
        ack_pct = 50; dre_pct = 0;
        issue(2, 1'b0, 24'h012345, 16'hBEEF, n);
        wait_idle(50);
        cmp("t1_wr_ack_once", ack_cnt[2], 1);
        ren_seen = '0; rdata_seen = '0; dre_pct = 100;
        issue(2, 1'b1, 24'h012345, 16'h0000, n);
        wait_idle(50);
        cmp("t1_rd_ack_once", ack_cnt[2], 2);
        cmp("t1_ren_port", ren_seen, 4'b0100);
        cmp("t1_rdata", rdata_seen, 16'hBEEF);

        // All ports request continuously: RR order and fixed-priority comparison.
        do_reset();
        auto_req = 1; req_pct = 100; ack_pct = 100; dre_pct = 50;
        k = 0; fgr = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            step();
            if (p_ack != '0) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (p_ack[i]) idx = i;
                cmp("rr_order", idx, k % N);
                k++;
            end
            if (f_p_ack != '0) begin
                cmp("fixed_only_port0", f_p_ack, 4'b0001);
                fgr++;
            end
        end
        cmp("rr_grants_seen", k >= 8, 1'b1);
        cmp("fixed_grants_seen", fgr >= 8, 1'b1);
        auto_req = 0; p_req = '0;
        wait_idle(100);

        // sdram_ack withheld for 40 cycles: request and held command stay put.
        ack_block = 1;
        issue(3, 1'b0, 24'hABCDEF, 16'h1234, n);
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            cmp("refresh_hold", {sdram_addr, sdram_rh_wl, sdram_data_w, sdram_req, busy},
                {24'hABCDEF, 1'b0, 16'h1234, 1'b1, 1'b1});
        end
        ack_block = 0; ack_pct = 100;
        wait_idle(50);

        // Read from port 1 never answered: error after RDT cycles in RD_WAIT.
        dre_block = 1;
        issue(1, 1'b1, 24'h000777, 16'h0, n);
        rd_cnt = 0; c = 0;
        while (p_err == '0 && c < 100) begin
            step(); c++;
            if (p_err == '0 && busy && !sdram_req) rd_cnt++;
        end
        cmp("timeout_err", p_err, 4'b0010);
        cmp("timeout_cycles", rd_cnt, RDT);
        cmp("timeout_idle", busy, 1'b0);
        step();

        // Reset in the middle of a read, then a normal request.
        issue(0, 1'b1, 24'h000888, 16'h0, n);
        c = 0;
        while (!(busy && !sdram_req) && c < 50) begin step(); c++; end
        cmp("in_rd_wait", busy && !sdram_req, 1'b1);
        for (int cyc = 0; cyc < 3; cyc++) step();
        do_reset();
        dre_block = 0;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        issue(2, 1'b0, 24'h000999, 16'h5A5A, n);
        wait_idle(50);
        cmp("post_reset_ack", ack_cnt[2], 1);

        // Randomized traffic under varied stub behaviour.
        auto_req = 1;
        for (int seg = 0; seg < 6; seg++) begin
            ack_pct = $urandom_range(10, 100);
            dre_pct = $urandom_range(0, 60);
            req_pct = $urandom_range(5, 80);
            for (int cyc = 0; cyc < 400; cyc++) begin
                step();
                if (seg == 3 && cyc == 200) do_reset();
            end
        end
        auto_req = 0; p_req = '0;
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
